// File: rtl/aes_ocl_ctrl.sv
// AXI-Lite register front end and sequencing FSM for an external AES-256 core.
// Holds key/plaintext, times the fixed core latency and captures the ciphertext.
module aes_ocl_ctrl #(
  parameter int          AES_LATENCY  = 29,
  parameter logic [31:0] UNIMPL_VALUE = 32'hDEAD_BEEF
) (
  input  logic         clk_main_a0,
  input  logic         rst_main_n,
  input  logic         awvalid,
  input  logic [31:0]  awaddr,
  output logic         awready,
  input  logic         wvalid,
  input  logic [31:0]  wdata,
  input  logic [3:0]   wstrb,
  output logic         wready,
  output logic         bvalid,
  output logic [1:0]   bresp,
  input  logic         bready,
  input  logic         arvalid,
  input  logic [31:0]  araddr,
  output logic         arready,
  output logic         rvalid,
  output logic [31:0]  rdata,
  output logic [1:0]   rresp,
  input  logic         rready,
  output logic [127:0] aes_state,
  output logic [255:0] aes_key,
  input  logic [127:0] aes_out,
  output logic [15:0]  vled
);

  // state | meaning
  // IDLE  | waiting for START; KEY/IN writable
  // LOAD  | busy set, done cleared, latency timer loaded
  // WAIT  | timer counting down; core inputs frozen
  // DONE  | ciphertext captured; done set, busy cleared
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT, ST_DONE} state_t;

  localparam int             CW       = (AES_LATENCY > 1) ? $clog2(AES_LATENCY) : 1;
  localparam logic [CW-1:0]  CNT_INIT = CW'(AES_LATENCY - 1);

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_busy, r_done;

  logic          r_wr_active, r_bvalid;
  logic [5:0]    r_awaddr;
  logic [1:0]    r_bresp, w_bresp_nxt;

  logic          r_ar_pending, r_rvalid;
  logic [5:0]    r_araddr;
  logic [31:0]   r_rdata, w_rdata_mux;

  logic [31:0]   r_key [8];
  logic [31:0]   r_in  [4];
  logic [31:0]   r_out [4];
  logic [15:0]   r_vled;

  logic w_aw_hs, w_is_key, w_is_in, w_is_ctrl, w_locked;
  logic w_start, w_wr_key, w_wr_in;
  logic w_load, w_cnt_zero, w_capture, w_done_st;
  logic w_unused_bits;

  assign w_unused_bits = ^{awaddr[31:8], awaddr[1:0], araddr[31:8], araddr[1:0]};

  function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                          input logic [31:0] new_v,
                                          input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[b*8 +: 8] = new_v[b*8 +: 8];
    return res;
  endfunction

  // write channel
  assign awready = ~r_wr_active;
  assign w_aw_hs = awvalid & ~r_wr_active;
  assign wready  = r_wr_active & wvalid & ~r_bvalid;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;

  assign w_is_key  = (r_awaddr[5:3] == 3'b000);
  assign w_is_in   = (r_awaddr[5:2] == 4'b0010);
  assign w_is_ctrl = (r_awaddr == 6'd12);

  assign w_start  = wready & w_is_ctrl & wdata[0] & ~w_locked;
  assign w_wr_key = wready & w_is_key & ~w_locked;
  assign w_wr_in  = wready & w_is_in  & ~w_locked;

  // busy-time KEY/IN writes and START are refused; RO/unmapped writes silently drop
  assign w_bresp_nxt = (((w_is_key | w_is_in) & w_locked) |
                        (w_is_ctrl & wdata[0] & w_locked)) ? 2'b10 : 2'b00;

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_wr_active <= 1'b0;
      r_awaddr    <= '0;
      r_bvalid    <= 1'b0;
      r_bresp     <= 2'b00;
    end else begin
      if (w_aw_hs) begin
        r_wr_active <= 1'b1;
        r_awaddr    <= awaddr[7:2];
      end
      if (wready) begin
        r_bvalid <= 1'b1;
        r_bresp  <= w_bresp_nxt;
      end else if (r_bvalid && bready) begin
        r_bvalid    <= 1'b0;
        r_wr_active <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int i = 0; i < 8; i++) r_key[i] <= '0;
      for (int i = 0; i < 4; i++) r_in[i]  <= '0;
    end else begin
      if (w_wr_key) r_key[r_awaddr[2:0]] <= f_merge(r_key[r_awaddr[2:0]], wdata, wstrb);
      if (w_wr_in)  r_in[r_awaddr[1:0]]  <= f_merge(r_in[r_awaddr[1:0]], wdata, wstrb);
    end
  end

  assign aes_state = {r_in[3], r_in[2], r_in[1], r_in[0]};
  assign aes_key   = {r_key[7], r_key[6], r_key[5], r_key[4],
                      r_key[3], r_key[2], r_key[1], r_key[0]};

  // read channel: data is sampled one cycle after accept so a same-cycle capture wins
  assign arready = ~r_ar_pending & ~r_rvalid;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = 2'b00;

  always_comb begin
    w_rdata_mux = UNIMPL_VALUE;
    if (r_araddr[5:3] == 3'b000)       w_rdata_mux = r_key[r_araddr[2:0]];
    else if (r_araddr[5:2] == 4'b0010) w_rdata_mux = r_in[r_araddr[1:0]];
    else if (r_araddr == 6'd12)        w_rdata_mux = 32'h0;
    else if (r_araddr == 6'd13)        w_rdata_mux = {30'b0, r_done, r_busy};
    else if (r_araddr[5:2] == 4'b0100) w_rdata_mux = r_out[r_araddr[1:0]];
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_ar_pending <= 1'b0;
      r_araddr     <= '0;
      r_rvalid     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      if (arvalid && arready) begin
        r_ar_pending <= 1'b1;
        r_araddr     <= araddr[7:2];
      end
      if (r_ar_pending) begin
        r_ar_pending <= 1'b0;
        r_rvalid     <= 1'b1;
        r_rdata      <= w_rdata_mux;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // sequencing FSM
  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) r_state <= ST_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD: w_state_nxt = ST_WAIT;
      ST_WAIT: if (w_cnt_zero) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_locked   = (r_state != ST_IDLE);
    w_load     = (r_state == ST_LOAD);
    w_cnt_zero = (r_cnt == '0);
    w_capture  = (r_state == ST_WAIT) & w_cnt_zero;
    w_done_st  = (r_state == ST_DONE);
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_load) begin
        r_cnt  <= CNT_INIT;
        r_busy <= 1'b1;
        r_done <= 1'b0;
      end else if ((r_state == ST_WAIT) && !w_cnt_zero) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_done_st) begin
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
    if (!rst_main_n) begin
      for (int i = 0; i < 4; i++) r_out[i] <= '0;
      r_vled <= '0;
    end else begin
      if (w_capture)
        for (int i = 0; i < 4; i++) r_out[i] <= aes_out[i*32 +: 32];
      r_vled <= r_out[0][15:0];
    end
  end

  assign vled = r_vled;

endmodule

// File: tb/tb_aes_ocl_ctrl.sv
// Directed bench for aes_ocl_ctrl with a behavioural AES stub and an expected-value queue.
module tb_aes_ocl_ctrl;
  localparam int L = 29;
  localparam logic [255:0] FK = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk, rst_n;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [127:0] aes_state, aes_out;
  logic [255:0] aes_key;
  logic [15:0] vled;

  aes_ocl_ctrl #(.AES_LATENCY(L), .UNIMPL_VALUE(32'hDEAD_BEEF)) dut (
    .clk_main_a0(clk), .rst_main_n(rst_n),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
    .aes_state(aes_state), .aes_key(aes_key), .aes_out(aes_out), .vled(vled)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_wbeat = 0;
  string       tag_q[$];
  logic [31:0] val_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // AES core stand-in: known vector gives the FIPS ciphertext, anything else a mixed value;
  // output is only meaningful once the inputs have been stable for most of the latency
  int stable = 0;
  logic [127:0] prev_s;
  logic [255:0] prev_k;
  function automatic logic [127:0] aes_model(input logic [127:0] s, input logic [255:0] k);
    if (s == FP && k == FK) return FC;
    return s ^ k[127:0] ^ k[255:128] ^ 128'h5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a_5a5a;
  endfunction
  always @(negedge clk) begin
    if (aes_state === prev_s && aes_key === prev_k) begin
      if (stable < 1000) stable = stable + 1;
    end else stable = 0;
    prev_s = aes_state;
    prev_k = aes_key;
  end
  assign aes_out = (stable >= L - 2) ? aes_model(aes_state, aes_key) : 128'h0bad_0bad_0bad_0bad_0bad_0bad_0bad_0bad;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed=timeout expected=handshake", tag);
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input logic [1:0] exp_resp, input string tag);
    int n;
    tag_q.push_back(tag);
    val_q.push_back({30'b0, exp_resp});
    @(negedge clk);
    awvalid = 1'b1; awaddr = addr; wvalid = 1'b1; wdata = data; wstrb = strb;
    n = 0;
    while (!awready && n < 50) begin @(negedge clk); n++; end
    if (!awready) timeout_fail({tag, " aw"});
    @(negedge clk);
    awvalid = 1'b0;
    n = 0;
    while (!wready && n < 50) begin @(negedge clk); n++; end
    if (!wready) timeout_fail({tag, " w"});
    last_wbeat = cyc + 1;
    @(negedge clk);
    wvalid = 1'b0; bready = 1'b1;
    n = 0;
    while (!bvalid && n < 50) begin @(negedge clk); n++; end
    if (!bvalid) timeout_fail({tag, " b"});
    chk(tag_q.pop_front(), 256'(bresp), 256'(val_q.pop_front()));
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [31:0] exp, input string tag, input int hold);
    int n;
    string t;
    logic [31:0] e;
    tag_q.push_back(tag);
    val_q.push_back(exp);
    @(negedge clk);
    arvalid = 1'b1; araddr = addr; rready = 1'b0;
    n = 0;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (!arready) timeout_fail({tag, " ar"});
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) timeout_fail({tag, " r"});
    t = tag_q.pop_front();
    e = val_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      chk({t, " hold rdata"}, 256'(rdata), 256'(e));
      chk({t, " hold arready"}, 256'(arready), 256'(0));
      @(negedge clk);
    end
    rready = 1'b1;
    chk(t, 256'(rdata), 256'(e));
    @(negedge clk);
    rready = 1'b0;
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " awready"}, 256'(awready), 256'(1));
    chk({tag, " arready"}, 256'(arready), 256'(1));
    chk({tag, " bvalid"}, 256'(bvalid), 256'(0));
    chk({tag, " rvalid"}, 256'(rvalid), 256'(0));
    chk({tag, " rdata"}, 256'(rdata), 256'(0));
    chk({tag, " vled"}, 256'(vled), 256'(0));
    chk({tag, " aes_state"}, 256'(aes_state), 256'(0));
    chk({tag, " aes_key"}, aes_key, 256'(0));
  endtask

  task automatic write_fips();
    logic [255:0] k;
    logic [127:0] p;
    k = FK;
    p = FP;
    for (int i = 0; i < 8; i++) axi_write(32'(i * 4), k[i*32 +: 32], 4'hF, 2'b00, "wr_key");
    for (int i = 0; i < 4; i++) axi_write(32'h20 + 32'(i * 4), p[i*32 +: 32], 4'hF, 2'b00, "wr_in");
  endtask

  task automatic start_and_time(input logic [15:0] prev_vled, input string tag);
    int b, n;
    axi_write(32'h30, 32'h1, 4'hF, 2'b00, {tag, " start"});
    b = last_wbeat;
    n = 0;
    while (vled === prev_vled && n < 100) begin @(negedge clk); n++; end
    if (vled === prev_vled) timeout_fail({tag, " vled"});
    else chk({tag, " latency"}, 256'(cyc - b), 256'(L + 2));
    chk({tag, " vled"}, 256'(vled), 256'(16'h6089));
  endtask

  task automatic check_out(input string tag);
    logic [127:0] c;
    c = FC;
    for (int i = 0; i < 4; i++) axi_read(32'h40 + 32'(i * 4), c[i*32 +: 32], tag, 0);
  endtask

  initial begin
    int b;
    rst_n = 1'b0;
    awvalid = 0; awaddr = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; rready = 0;
    repeat (3) @(negedge clk);
    reset_checks("rst");
    rst_n = 1'b1;
    @(negedge clk);
    axi_read(32'h34, 32'h0, "status_rst", 0);
    axi_read(32'h40, 32'h0, "out0_rst", 0);
    axi_read(32'h30, 32'h0, "ctrl_rd", 0);

    axi_write(32'h20, 32'hAABBCCDD, 4'b0010, 2'b00, "in0_strb_wr");
    axi_read(32'h20, 32'h0000CC00, "in0_strb", 0);

    write_fips();
    chk("aes_key_fips", aes_key, FK);
    chk("aes_state_fips", 256'(aes_state), 256'(FP));
    axi_read(32'h1C, 32'h00010203, "key7_rd", 0);
    axi_read(32'h2C, 32'h00112233, "in3_rd", 0);

    start_and_time(16'h0, "run1");
    axi_read(32'h34, 32'h2, "status_done", 0);
    check_out("out_run1");

    axi_write(32'h30, 32'h1, 4'hF, 2'b00, "start_run2");
    b = last_wbeat;
    axi_write(32'h00, 32'hFFFFFFFF, 4'hF, 2'b10, "key0_busy");
    chk("aes_key_held", aes_key, FK);
    axi_read(32'h34, 32'h1, "status_busy", 0);
    axi_read(32'h00, 32'h1c1d1e1f, "key0_unchanged", 0);
    while (cyc < b + 35) @(negedge clk);
    axi_read(32'h34, 32'h2, "status_run2", 0);
    check_out("out_run2");

    axi_write(32'h30, 32'h1, 4'hF, 2'b00, "start_run3");
    b = last_wbeat;
    axi_write(32'h30, 32'h1, 4'hF, 2'b10, "start_busy");
    while (cyc < b + 31) @(negedge clk);
    axi_read(32'h34, 32'h2, "status_single", 0);
    repeat (40) @(negedge clk);
    axi_read(32'h34, 32'h2, "status_single_late", 0);
    axi_read(32'h40, 32'h4b496089, "out0_run3", 0);

    axi_read(32'h7C, 32'hDEAD_BEEF, "unmapped_7c", 5);
    axi_read(32'h38, 32'hDEAD_BEEF, "unmapped_38", 0);
    axi_write(32'h34, 32'hFFFFFFFF, 4'hF, 2'b00, "wr_status_ro");
    axi_write(32'h40, 32'h0, 4'hF, 2'b00, "wr_out_ro");
    axi_write(32'h7C, 32'h12345678, 4'hF, 2'b00, "wr_unmapped");
    axi_read(32'h40, 32'h4b496089, "out0_after_ro", 0);

    axi_write(32'h30, 32'h1, 4'hF, 2'b00, "start_abort");
    b = last_wbeat;
    while (cyc < b + 12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    reset_checks("rst_mid");
    rst_n = 1'b1;
    axi_read(32'h34, 32'h0, "status_abort", 0);
    axi_read(32'h40, 32'h0, "out0_abort", 0);
    write_fips();
    start_and_time(16'h0, "run4");
    axi_read(32'h34, 32'h2, "status_run4", 0);
    axi_read(32'h4C, 32'h8ea2b7ca, "out3_run4", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
